fx_arb: RTL and testbench
=========================

FX_ARB -- requirements
Module: fx_arb

Interface
REQ-001 SHALL have parameter STB_W, default 2: fx_rd/fx_wr strobe width in clk_sys cycles, legal range 1..15.
REQ-002 SHALL have port clk_sys, input, 1: system clock; all flops rising-edge.
REQ-003 SHALL have port rst, input, 1: reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port req_vld, input, 2: per-requester transaction request; bit0 = host, bit1 = dsp engine.
REQ-005 SHALL have port req_wr, input, 2: per-requester direction; 1 = write, 0 = read.
REQ-006 SHALL have port req_addr, input, 32: requester n address in bits [16n+15:16n].
REQ-007 SHALL have port req_wdat, input, 16: requester n write data in bits [8n+7:8n].
REQ-008 SHALL have port req_rdy, output, 2: one-hot acceptance; transfer occurs on the edge where req_vld[n] & req_rdy[n].
REQ-009 SHALL have port req_done, output, 2: one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port req_rdat, output, 8: read data; valid while req_done is nonzero.
REQ-011 SHALL have port req_err, output, 1: decode error flag; valid while req_done is nonzero.
REQ-012 SHALL have port fx_a, output, 16: bus address.
REQ-013 SHALL have port fx_data, output, 8: bus write data.
REQ-014 SHALL have port fx_cs, output, 5: one-hot slave select; bit0 syn, bit1 ad1, bit2 ad2, bit3 ad3, bit4 dsp.
REQ-015 SHALL have ports fx_rd and fx_wr, output, 1 each: bus strobes.
REQ-016 SHALL have port fx_q, input, 8: OR-combined slave read data; slaves drive 0 when not selected.

Function
REQ-017 SHALL implement the FSM states IDLE, SETUP, STB and DONE.
REQ-018 IDLE: if req_vld is nonzero, SHALL combinationally assert req_rdy for the granted requester only; req_rdy SHALL be 0 in every other state.
REQ-019 Arbitration SHALL be round-robin: on a tie the requester not served last wins; after reset, requester 0 wins a tie.
REQ-020 On acceptance SHALL latch addr, wr, wdat and the grant index; later changes on the req inputs SHALL be ignored until the next IDLE.
REQ-021 Decode SHALL use fx_a[15:12]: 0..4 map to fx_cs bit 0..4; values 5..15 are a decode error.
REQ-022 Valid decode: IDLE goes to SETUP, SETUP lasts 1 cycle, then STB.
REQ-023 SETUP SHALL drive fx_a, fx_cs and fx_data (writes only; 0 for reads) with both strobes low.
REQ-024 STB SHALL hold fx_a, fx_cs and fx_data stable and assert fx_rd or fx_wr for exactly STB_W cycles, counted by a 4-bit counter.
REQ-025 Reads SHALL sample fx_q into req_rdat on the last STB cycle.
REQ-026 After STB the FSM SHALL enter DONE for 1 cycle: fx_cs, strobes, fx_a and fx_data = 0; req_done[g] = 1; then return to IDLE.
REQ-027 Decode error: IDLE goes directly to DONE; no fx_cs or strobe is asserted; req_err = 1 and req_rdat = 0.
REQ-028 Latency: with acceptance at edge T, req_done SHALL be high in cycle T+2+STB_W for a valid decode and T+1 for an error.
REQ-029 Write completion SHALL drive req_rdat = 0 and req_err = 0.
REQ-030 req_done, req_err and req_rdat SHALL be registered outputs.
REQ-031 At most one transaction SHALL be outstanding; a new acceptance SHALL be possible in the cycle after DONE.
REQ-032 fx_rd and fx_wr SHALL never be high together, and at most one fx_cs bit SHALL be high at any time.

Reset
REQ-033 While rst = 1, SHALL immediately force all outputs to 0, the state to IDLE, the counter to 0 and the round-robin pointer to "last = 1".
REQ-034 Reset mid-transaction SHALL abort it silently: no req_done is issued and strobes fall asynchronously.
REQ-035 After rst deasserts, the first acceptance SHALL be possible on the first clk_sys edge.

Verification
REQ-036 Host read 0x2010, STB_W=2, fx_q=0xA5 during STB -> fx_cs=00100; fx_rd high 2 cycles; req_done=01 at T+4; req_rdat=0xA5; req_err=0.
REQ-037 Dsp write 0x4003 with data 0x3C -> fx_cs=10000; fx_data=0x3C; fx_wr high 2 cycles; req_done=10 at T+4; req_rdat=0.
REQ-038 Both requesters valid continuously from reset -> grant order 0,1,0,1; each req_rdy is a one-cycle pulse in IDLE.
REQ-039 Host read 0x7000 -> no fx_cs or strobe asserted; req_done=01 at T+1; req_err=1; req_rdat=0.
REQ-040 rst asserted in the first STB cycle -> fx_rd and fx_cs go to 0 without waiting for a clock edge; no req_done; a fresh request after release completes normally.

Source files
------------

// File: rtl/fx_arb.sv
// fx_arb: two-requester round-robin arbiter in front of a strobed 8-bit fx slave bus.
// The top address nibble selects one of five slaves; other nibbles complete at once with req_err.
module fx_arb #(
  parameter int STB_W = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [1:0]  req_vld,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdat,
  output logic [1:0]  req_rdy,
  output logic [1:0]  req_done,
  output logic [7:0]  req_rdat,
  output logic        req_err,
  output logic [15:0] fx_a,
  output logic [7:0]  fx_data,
  output logic [4:0]  fx_cs,
  output logic        fx_rd,
  output logic        fx_wr,
  input  logic [7:0]  fx_q
);

  // state | meaning
  // IDLE  | waiting; req_rdy offered combinationally to the arbitration winner
  // SETUP | fx_a, fx_cs, fx_data driven, strobes low
  // STB   | fx_rd or fx_wr high for STB_W cycles (down-counter to zero)
  // DONE  | bus released, req_done pulsed to the granted requester
  typedef enum logic [1:0] {IDLE, SETUP, STB, DONE} state_t;

  localparam logic [3:0] STB_LAST = 4'(STB_W - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_q;
  logic        gnt_q;
  logic        wr_q;
  logic [15:0] fx_a_q;
  logic [7:0]  fx_data_q;
  logic [4:0]  fx_cs_q;
  logic        fx_rd_q;
  logic        fx_wr_q;
  logic [1:0]  done_q;
  logic [7:0]  rdat_q;
  logic        err_q;

  logic        gnt_d;
  logic        acc_d;
  logic        wr_d;
  logic        dec_ok_d;
  logic [15:0] addr_d;
  logic [7:0]  wdat_d;
  logic [4:0]  cs_d;
  logic [1:0]  gnt_oh_d;

  always_comb begin
    // on a tie the requester not served last wins
    gnt_d    = (req_vld == 2'b11) ? ~last_q : req_vld[1];
    acc_d    = (state_q == IDLE) && (req_vld != 2'b00) && !rst;
    addr_d   = gnt_d ? req_addr[31:16] : req_addr[15:0];
    wdat_d   = gnt_d ? req_wdat[15:8]  : req_wdat[7:0];
    wr_d     = gnt_d ? req_wr[1]       : req_wr[0];
    gnt_oh_d = gnt_d ? 2'b10 : 2'b01;
    dec_ok_d = 1'b1;
    cs_d     = 5'b00000;
    case (addr_d[15:12])
      4'd0:    cs_d = 5'b00001;
      4'd1:    cs_d = 5'b00010;
      4'd2:    cs_d = 5'b00100;
      4'd3:    cs_d = 5'b01000;
      4'd4:    cs_d = 5'b10000;
      default: dec_ok_d = 1'b0;
    endcase
  end

  assign req_rdy  = acc_d ? gnt_oh_d : 2'b00;
  assign req_done = done_q;
  assign req_rdat = rdat_q;
  assign req_err  = err_q;
  assign fx_a     = fx_a_q;
  assign fx_data  = fx_data_q;
  assign fx_cs    = fx_cs_q;
  assign fx_rd    = fx_rd_q;
  assign fx_wr    = fx_wr_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      wr_q      <= 1'b0;
      fx_a_q    <= 16'h0000;
      fx_data_q <= 8'h00;
      fx_cs_q   <= 5'b00000;
      fx_rd_q   <= 1'b0;
      fx_wr_q   <= 1'b0;
      done_q    <= 2'b00;
      rdat_q    <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_d) begin
            last_q <= gnt_d;
            gnt_q  <= gnt_d;
            wr_q   <= wr_d;
            if (dec_ok_d) begin
              state_q   <= SETUP;
              fx_a_q    <= addr_d;
              fx_cs_q   <= cs_d;
              fx_data_q <= wr_d ? wdat_d : 8'h00;
            end else begin
              state_q <= DONE;
              done_q  <= gnt_oh_d;
              err_q   <= 1'b1;
              rdat_q  <= 8'h00;
            end
          end
        end
        SETUP: begin
          state_q <= STB;
          cnt_q   <= STB_LAST;
          fx_rd_q <= ~wr_q;
          fx_wr_q <= wr_q;
        end
        STB: begin
          if (cnt_q == 4'd0) begin
            state_q   <= DONE;
            fx_rd_q   <= 1'b0;
            fx_wr_q   <= 1'b0;
            fx_a_q    <= 16'h0000;
            fx_cs_q   <= 5'b00000;
            fx_data_q <= 8'h00;
            done_q    <= gnt_q ? 2'b10 : 2'b01;
            err_q     <= 1'b0;
            rdat_q    <= wr_q ? 8'h00 : fx_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 2'b00;
          err_q   <= 1'b0;
          rdat_q  <= 8'h00;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_arb.sv
// tb_fx_arb: directed literal scenarios plus randomized traffic checked every cycle
// against a transaction-timeline model of the arbiter and fx bus.
module tb_fx_arb;
  localparam int W = 2;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [1:0]  req_vld, req_wr, req_rdy, req_done;
  logic [31:0] req_addr;
  logic [15:0] req_wdat, fx_a;
  logic [7:0]  req_rdat, fx_data, fx_q;
  logic        req_err, fx_rd, fx_wr;
  logic [4:0]  fx_cs;
  logic        q_fix_en;

  int n_cmp = 0;
  int n_bad = 0;

  fx_arb #(.STB_W(W)) dut (
    .clk_sys(clk_sys), .rst(rst), .req_vld(req_vld), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdat(req_wdat), .req_rdy(req_rdy),
    .req_done(req_done), .req_rdat(req_rdat), .req_err(req_err),
    .fx_a(fx_a), .fx_data(fx_data), .fx_cs(fx_cs), .fx_rd(fx_rd),
    .fx_wr(fx_wr), .fx_q(fx_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave model: selected slave drives data, unselected slaves drive 0.
  initial begin
    fx_q = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      fx_q = (fx_cs != 5'b0) ? (q_fix_en ? 8'hA5 : 8'($urandom)) : 8'h00;
    end
  end

  // Timeline model: m_age counts cycles since the acceptance edge.
  int          m_busy = 0, m_age = 0, m_last = 1, m_gnt = 0, g = 0;
  logic        m_wr, m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_wdat, m_rdat;
  logic [1:0]  e_rdy, e_done;
  logic [7:0]  e_rdat, e_data;
  logic        e_err, e_rd, e_wr;
  logic [15:0] e_a;
  logic [4:0]  e_cs;

  always @(negedge clk_sys) begin
    e_rdy = 0; e_done = 0; e_rdat = 0; e_err = 0; e_a = 0; e_data = 0;
    e_cs = 0; e_rd = 0; e_wr = 0;
    if (rst) begin
      m_busy = 0;
      m_last = 1;
    end else if (!m_busy) begin
      if (req_vld != 2'b00) begin
        g = (req_vld == 2'b11) ? (1 - m_last) : (req_vld[1] ? 1 : 0);
        e_rdy = (g == 1) ? 2'b10 : 2'b01;
      end
    end else if (m_err) begin
      e_done = (m_gnt == 1) ? 2'b10 : 2'b01;
      e_err  = 1'b1;
    end else if (m_age <= W + 1) begin
      e_a    = m_addr;
      e_cs   = 5'(1 << m_addr[15:12]);
      e_data = m_wr ? m_wdat : 8'h00;
      if (m_age >= 2) begin
        e_rd = ~m_wr;
        e_wr = m_wr;
      end
      if (m_age == W + 1) m_rdat = m_wr ? 8'h00 : fx_q;
    end else begin
      e_done = (m_gnt == 1) ? 2'b10 : 2'b01;
      e_rdat = m_rdat;
    end

    chk("req_rdy", 32'(req_rdy), 32'(e_rdy));
    chk("req_done", 32'(req_done), 32'(e_done));
    chk("req_rdat", 32'(req_rdat), 32'(e_rdat));
    chk("req_err", 32'(req_err), 32'(e_err));
    chk("fx_a", 32'(fx_a), 32'(e_a));
    chk("fx_cs", 32'(fx_cs), 32'(e_cs));
    chk("fx_data", 32'(fx_data), 32'(e_data));
    chk("fx_rd", 32'(fx_rd), 32'(e_rd));
    chk("fx_wr", 32'(fx_wr), 32'(e_wr));

    if (!rst) begin
      if (!m_busy && e_rdy != 2'b00) begin
        m_busy = 1;
        m_age  = 1;
        m_gnt  = g;
        m_last = g;
        m_addr = (g == 1) ? req_addr[31:16] : req_addr[15:0];
        m_wdat = (g == 1) ? req_wdat[15:8] : req_wdat[7:0];
        m_wr   = req_wr[g];
        m_err  = (m_addr[15:12] > 4'd4);
      end else if (m_busy) begin
        m_age++;
        if (m_age > (m_err ? 1 : W + 2)) m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One isolated request with hand-computed expectations, checked edge by edge.
  task automatic directed(input string nm, input logic [1:0] vld, input logic wr,
                          input logic [15:0] addr, input logic [7:0] wdat,
                          input logic [4:0] ecs, input logic [7:0] erdat);
    req_vld = vld; req_wr = {wr, wr}; req_addr = {addr, addr}; req_wdat = {wdat, wdat};
    #1;
    chk({nm, "_rdy"}, 32'(req_rdy), 32'(vld));
    tick();
    req_vld = 2'b00; req_addr = 32'hFFFF_FFFF; req_wdat = 16'hFFFF; req_wr = ~req_wr;
    if (ecs == 5'b0) begin
      chk({nm, "_done"}, 32'(req_done), 32'(vld));
      chk({nm, "_err"}, 32'(req_err), 32'd1);
      chk({nm, "_rdat"}, 32'(req_rdat), 32'd0);
      chk({nm, "_bus"}, {fx_cs, fx_rd, fx_wr}, 32'd0);
    end else begin
      chk({nm, "_setup_cs"}, 32'(fx_cs), 32'(ecs));
      chk({nm, "_setup_a"}, 32'(fx_a), 32'(addr));
      chk({nm, "_setup_data"}, 32'(fx_data), wr ? 32'(wdat) : 32'd0);
      chk({nm, "_setup_stb"}, {fx_rd, fx_wr}, 32'd0);
      for (int i = 0; i < W; i++) begin
        tick();
        chk({nm, "_stb_cs"}, 32'(fx_cs), 32'(ecs));
        chk({nm, "_stb"}, {fx_rd, fx_wr}, wr ? 32'd1 : 32'd2);
        chk({nm, "_stb_data"}, 32'(fx_data), wr ? 32'(wdat) : 32'd0);
        chk({nm, "_stb_done"}, 32'(req_done), 32'd0);
      end
      tick();
      chk({nm, "_done"}, 32'(req_done), 32'(vld));
      chk({nm, "_rdat"}, 32'(req_rdat), 32'(erdat));
      chk({nm, "_err"}, 32'(req_err), 32'd0);
      chk({nm, "_done_bus"}, {fx_a, fx_cs, fx_rd, fx_wr}, 32'd0);
    end
    tick();
    chk({nm, "_after"}, 32'(req_done), 32'd0);
  endtask

  initial begin
    int ec, prev, guard;
    logic [1:0] exp_g;
    rst = 1'b1; q_fix_en = 1'b0;
    req_vld = 2'b11; req_wr = 2'b10; req_addr = 32'h1234_0123; req_wdat = 16'h5A00;
    #3;
    chk("rst_rdy", 32'(req_rdy), 32'd0);
    chk("rst_outs", {req_done, req_err, fx_cs, fx_rd, fx_wr}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    // both requesters valid from reset: grants 0,1,0,1 spaced W+3 edges apart
    ec = 0; prev = 0;
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (req_rdy == 2'b00 && guard < 20) begin
        tick(); ec++; guard++;
      end
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_grant", 32'(req_rdy), 32'(exp_g));
      if (k == 0) chk("rr_first_edge", 32'(ec), 32'd0);
      else chk("rr_gap", 32'(ec - prev), 32'(W + 3));
      prev = ec;
      tick(); ec++;
      chk("rr_pulse", 32'(req_rdy), 32'd0);
    end
    req_vld = 2'b00;
    repeat (8) tick();

    q_fix_en = 1'b1;
    directed("host_rd", 2'b01, 1'b0, 16'h2010, 8'h00, 5'b00100, 8'hA5);
    directed("dsp_wr", 2'b10, 1'b1, 16'h4003, 8'h3C, 5'b10000, 8'h00);
    directed("dec_err", 2'b01, 1'b0, 16'h7000, 8'h00, 5'b00000, 8'h00);

    // reset in the first strobe cycle aborts silently and asynchronously
    req_vld = 2'b01; req_wr = 2'b00; req_addr = 32'h0000_2010;
    tick();
    req_vld = 2'b00;
    tick();
    #1;
    chk("abort_pre_rd", 32'(fx_rd), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rd", 32'(fx_rd), 32'd0);
    chk("abort_cs", 32'(fx_cs), 32'd0);
    tick();
    chk("abort_done", 32'(req_done), 32'd0);
    rst = 1'b0;
    directed("post_rst", 2'b01, 1'b0, 16'h1005, 8'h00, 5'b00010, 8'hA5);
    q_fix_en = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      req_vld  = {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)};
      req_wr   = 2'($urandom);
      req_addr = {4'($urandom_range(0, 7)), 12'($urandom), 4'($urandom_range(0, 7)), 12'($urandom)};
      req_wdat = 16'($urandom);
    end
    rst = 1'b0;
    req_vld = 2'b00;
    repeat (10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
